gmii_rx_framer: RTL and testbench

Receive-side GMII framer that consumes the byte-wide `gmii_den`/`gmii_din` stream from the RGMII-to-GMII converter in the `gmii_clk` domain. It delineates frames, strips preamble and SFD, and emits a byte stream with start/end markers. It also checks CRC-32 and frame length, and keeps per-port receive statistics for the tester's RX data path.

---
 rtl/gmii_rx_framer_if.sv | 53 +++++
 rtl/gmii_rx_framer.sv | 185 ++++++++++++++++++
 tb/tb_gmii_rx_framer.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gmii_rx_framer_if.sv
// GMII receive framer bundle: GMII byte input, framed byte output,
// end-of-frame status and receive statistics.
// Ports: gmii_den/gmii_din (stream in), rx_data/rx_valid/rx_sof/rx_eof
//   (stream out), rx_stat_valid/rx_crc_err/rx_len_err (status),
//   rx_frame_cnt/rx_crc_err_cnt/rx_len_err_cnt/rx_drop_cnt (counters).
// Modports: master = framer side, slave = source/consumer side.
interface gmii_rx_framer_if;
   logic        gmii_den;
   logic [7:0]  gmii_din;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_sof;
   logic        rx_eof;
   logic        rx_stat_valid;
   logic        rx_crc_err;
   logic        rx_len_err;
   logic [31:0] rx_frame_cnt;
   logic [31:0] rx_crc_err_cnt;
   logic [31:0] rx_len_err_cnt;
   logic [31:0] rx_drop_cnt;

   modport master (
      input  gmii_den,
      input  gmii_din,
      output rx_data,
      output rx_valid,
      output rx_sof,
      output rx_eof,
      output rx_stat_valid,
      output rx_crc_err,
      output rx_len_err,
      output rx_frame_cnt,
      output rx_crc_err_cnt,
      output rx_len_err_cnt,
      output rx_drop_cnt
   );

   modport slave (
      output gmii_den,
      output gmii_din,
      input  rx_data,
      input  rx_valid,
      input  rx_sof,
      input  rx_eof,
      input  rx_stat_valid,
      input  rx_crc_err,
      input  rx_len_err,
      input  rx_frame_cnt,
      input  rx_crc_err_cnt,
      input  rx_len_err_cnt,
      input  rx_drop_cnt
   );
endinterface

// File: rtl/gmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD, delineates frames, checks
// CRC-32 and length, and keeps receive statistics.
// Ports: gmii_clk (clock), rst (sync active-high reset),
//   rx_if (gmii_rx_framer_if.master, stream in/out, status, counters).
// Config macro RX_FCS_STRIP_EN: delay line depth 5, FCS removed from the
//   output stream; undefined: depth 1, FCS bytes are passed through.
module gmii_rx_framer #(
   parameter logic [10:0] MAX_LEN = 11'd1518,
   parameter logic [10:0] MIN_LEN = 11'd64
) (
   input logic              gmii_clk,
   input logic              rst,
   gmii_rx_framer_if.master rx_if
);

`ifdef RX_FCS_STRIP_EN
   localparam int D = 5;
`else
   localparam int D = 1;
`endif

   localparam logic [2:0]  DEPTH    = 3'(D);
   localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_GOOD = 32'hDEBB_20E3;
   localparam logic [7:0]  PRE      = 8'h55;
   localparam logic [7:0]  SFD      = 8'hD5;

   typedef enum logic [1:0] {
      IDLE,
      PREAMBLE,
      DATA,
      DROP
   } state_t;

   state_t          state;
   logic [8*D-1:0]  line;
   logic [8*D-1:0]  line_sh;
   logic [2:0]      fill;
   logic            sof_pend;
   logic [31:0]     crc;
   logic [10:0]     len;

   logic [7:0]      data_q;
   logic            valid_q;
   logic            sof_q;
   logic            eof_q;
   logic            stat_q;
   logic            crc_err_q;
   logic            len_err_q;
   logic [31:0]     frame_cnt;
   logic [31:0]     crc_cnt;
   logic [31:0]     len_cnt;
   logic [31:0]     drop_cnt;

   logic            crc_bad;
   logic            len_bad;
   logic [7:0]      oldest;

   // Reflected CRC-32, one byte, LSB first.
   function automatic logic [31:0] crc_next(
      input logic [31:0] c,
      input logic [7:0]  d
   );
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB8_8320;
         else             r = r >> 1;
      end
      return r;
   endfunction

   // Newest byte enters at the bottom, oldest sits at the top.
   always_comb begin
      line_sh      = line << 8;
      line_sh[7:0] = rx_if.gmii_din;
   end

   assign oldest  = line[8*D-1 -: 8];
   assign crc_bad = (crc != CRC_GOOD);
   assign len_bad = (len < MIN_LEN) || (len > MAX_LEN);

   always_ff @(posedge gmii_clk) begin
      if (rst) begin
         state     <= IDLE;
         line      <= '0;
         fill      <= '0;
         sof_pend  <= 1'b0;
         crc       <= CRC_INIT;
         len       <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         sof_q     <= 1'b0;
         eof_q     <= 1'b0;
         stat_q    <= 1'b0;
         crc_err_q <= 1'b0;
         len_err_q <= 1'b0;
         frame_cnt <= '0;
         crc_cnt   <= '0;
         len_cnt   <= '0;
         drop_cnt  <= '0;
      end else begin
         valid_q   <= 1'b0;
         sof_q     <= 1'b0;
         eof_q     <= 1'b0;
         stat_q    <= 1'b0;
         crc_err_q <= 1'b0;
         len_err_q <= 1'b0;

         unique case (state)
            IDLE, PREAMBLE: begin
               if (!rx_if.gmii_den) begin
                  // Preamble-only burst vanishes silently.
                  state <= IDLE;
               end else if (rx_if.gmii_din == PRE) begin
                  state <= PREAMBLE;
               end else if (rx_if.gmii_din == SFD) begin
                  state    <= DATA;
                  crc      <= CRC_INIT;
                  len      <= '0;
                  fill     <= '0;
                  line     <= '0;
                  sof_pend <= 1'b1;
               end else begin
                  state <= DROP;
               end
            end

            DATA: begin
               if (rx_if.gmii_den) begin
                  crc  <= crc_next(crc, rx_if.gmii_din);
                  line <= line_sh;
                  if (len != 11'h7FF) len <= len + 11'd1;
                  if (fill == DEPTH) begin
                     valid_q  <= 1'b1;
                     data_q   <= oldest;
                     sof_q    <= sof_pend;
                     sof_pend <= 1'b0;
                  end else begin
                     fill <= fill + 3'd1;
                  end
               end else begin
                  // End of frame: flush one beat, drop the rest.
                  state     <= IDLE;
                  stat_q    <= 1'b1;
                  crc_err_q <= crc_bad;
                  len_err_q <= len_bad;
                  if (fill == DEPTH) begin
                     valid_q <= 1'b1;
                     eof_q   <= 1'b1;
                     data_q  <= oldest;
                     sof_q   <= sof_pend;
                  end
                  fill     <= '0;
                  line     <= '0;
                  sof_pend <= 1'b0;
                  if (!crc_bad && !len_bad) frame_cnt <= frame_cnt + 32'd1;
                  if (crc_bad) crc_cnt <= crc_cnt + 32'd1;
                  if (len_bad) len_cnt <= len_cnt + 32'd1;
               end
            end

            DROP: begin
               if (!rx_if.gmii_den) begin
                  state    <= IDLE;
                  drop_cnt <= drop_cnt + 32'd1;
               end
            end
         endcase
      end
   end

   assign rx_if.rx_data        = data_q;
   assign rx_if.rx_valid       = valid_q;
   assign rx_if.rx_sof         = sof_q;
   assign rx_if.rx_eof         = eof_q;
   assign rx_if.rx_stat_valid  = stat_q;
   assign rx_if.rx_crc_err     = crc_err_q;
   assign rx_if.rx_len_err     = len_err_q;
   assign rx_if.rx_frame_cnt   = frame_cnt;
   assign rx_if.rx_crc_err_cnt = crc_cnt;
   assign rx_if.rx_len_err_cnt = len_cnt;
   assign rx_if.rx_drop_cnt    = drop_cnt;

endmodule

// File: tb/tb_gmii_rx_framer.sv
// Randomized self-checking bench for gmii_rx_framer.
// Bursts are scored by a frame-level reference model.
module tb_gmii_rx_framer;

`ifdef RX_FCS_STRIP_EN
   localparam int D = 5;
`else
   localparam int D = 1;
`endif

   typedef struct {
      int         cyc;
      logic       sof;
      logic       eof;
      logic [7:0] d;
   } beat_t;

   typedef struct {
      int   cyc;
      logic ce;
      logic le;
   } stat_t;

   logic gmii_clk;
   logic rst;
   int   cyc = 0;
   int   nvec = 0;
   int   nerr = 0;

   beat_t      obs_b[$];
   beat_t      exp_b[$];
   stat_t      obs_s[$];
   stat_t      exp_s[$];
   logic [7:0] cur_b[$];
   int         cur_c[$];

   logic [31:0] e_frame;
   logic [31:0] e_crc;
   logic [31:0] e_len;
   logic [31:0] e_drop;

   gmii_rx_framer_if bus ();

   gmii_rx_framer dut (
      .gmii_clk (gmii_clk),
      .rst      (rst),
      .rx_if    (bus)
   );

   initial begin
      gmii_clk = 1'b0;
      forever #5 gmii_clk = ~gmii_clk;
   end

   always @(posedge gmii_clk) cyc <= cyc + 1;

   always @(negedge gmii_clk) begin : mon
      beat_t b;
      stat_t s;
      if (!rst) begin
         if (bus.rx_valid) begin
            b.cyc = cyc;
            b.sof = bus.rx_sof;
            b.eof = bus.rx_eof;
            b.d   = bus.rx_data;
            obs_b.push_back(b);
         end
         if (bus.rx_stat_valid) begin
            s.cyc = cyc;
            s.ce  = bus.rx_crc_err;
            s.le  = bus.rx_len_err;
            obs_s.push_back(s);
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] want);
      nvec++;
      if (got !== want) begin
         nerr++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   function automatic logic [31:0] crc_upd(input logic [31:0] c,
                                           input logic [7:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++)
         r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   // Frame-level model of one den burst.
   task automatic model();
      int          n;
      int          i;
      int          fl;
      int          ln;
      int          nout;
      int          cl;
      logic [31:0] c;
      beat_t       bt;
      stat_t       st;
      n = cur_b.size();
      i = 0;
      if (n != 0) begin
         while (i < n && cur_b[i] == 8'h55) i++;
         if (i == n) begin
         end else if (cur_b[i] == 8'hD5) begin
            fl = n - i - 1;
            cl = cur_c[n-1];
            c  = 32'hFFFFFFFF;
            for (int j = 0; j < fl; j++) c = crc_upd(c, cur_b[i+1+j]);
            ln   = (fl > 2047) ? 2047 : fl;
            st.ce = (c != 32'hDEBB20E3);
            st.le = (ln < 64) || (ln > 1518);
            st.cyc = cl + 2;
            nout = (fl >= D) ? fl - D + 1 : 0;
            for (int j = 0; j < nout; j++) begin
               bt.d   = cur_b[i+1+j];
               bt.sof = (j == 0);
               bt.eof = (j == nout - 1);
               bt.cyc = (j + D < fl) ? cur_c[i+1+j+D] + 1 : cl + 2;
               exp_b.push_back(bt);
            end
            exp_s.push_back(st);
            if (!st.ce && !st.le) e_frame++;
            if (st.ce) e_crc++;
            if (st.le) e_len++;
         end else begin
            e_drop++;
         end
      end
      cur_b.delete();
      cur_c.delete();
   endtask

   task automatic drive_byte(input logic [7:0] b);
      @(posedge gmii_clk);
      #1;
      rst          = 1'b0;
      bus.gmii_den = 1'b1;
      bus.gmii_din = b;
      cur_b.push_back(b);
      cur_c.push_back(cyc);
   endtask

   task automatic end_burst(input int gap);
      model();
      for (int g = 0; g < gap; g++) begin
         @(posedge gmii_clk);
         #1;
         bus.gmii_den = 1'b0;
         bus.gmii_din = 8'($urandom);
      end
   endtask

   task automatic send_frame(input int npre, input int npay,
                             input bit fcs, input bit corrupt,
                             input int gap);
      logic [7:0]  q[$];
      logic [31:0] c;
      logic [7:0]  v;
      c = 32'hFFFFFFFF;
      for (int k = 0; k < npre; k++) q.push_back(8'h55);
      q.push_back(8'hD5);
      for (int k = 0; k < npay; k++) begin
         v = 8'($urandom);
         q.push_back(v);
         c = crc_upd(c, v);
      end
      if (fcs) begin
         c = ~c;
         q.push_back(c[7:0]);
         q.push_back(c[15:8]);
         q.push_back(c[23:16]);
         q.push_back(c[31:24]);
         if (corrupt) q[q.size()-1] = q[q.size()-1] ^ 8'h01;
      end
      foreach (q[k]) drive_byte(q[k]);
      end_burst(gap);
   endtask

   task automatic settle();
      repeat (4) @(negedge gmii_clk);
   endtask

   task automatic flush(input string tag);
      int m;
      settle();
      chk({tag, "_nbeat"}, 64'(obs_b.size()), 64'(exp_b.size()));
      chk({tag, "_nstat"}, 64'(obs_s.size()), 64'(exp_s.size()));
      m = (obs_b.size() < exp_b.size()) ? obs_b.size() : exp_b.size();
      for (int k = 0; k < m; k++)
         chk({tag, "_beat"},
             {32'(obs_b[k].cyc), 22'd0, obs_b[k].sof, obs_b[k].eof,
              obs_b[k].d},
             {32'(exp_b[k].cyc), 22'd0, exp_b[k].sof, exp_b[k].eof,
              exp_b[k].d});
      m = (obs_s.size() < exp_s.size()) ? obs_s.size() : exp_s.size();
      for (int k = 0; k < m; k++)
         chk({tag, "_stat"},
             {32'(obs_s[k].cyc), 30'd0, obs_s[k].ce, obs_s[k].le},
             {32'(exp_s[k].cyc), 30'd0, exp_s[k].ce, exp_s[k].le});
      chk({tag, "_frame_cnt"}, 64'(bus.rx_frame_cnt), 64'(e_frame));
      chk({tag, "_crc_cnt"}, 64'(bus.rx_crc_err_cnt), 64'(e_crc));
      chk({tag, "_len_cnt"}, 64'(bus.rx_len_err_cnt), 64'(e_len));
      chk({tag, "_drop_cnt"}, 64'(bus.rx_drop_cnt), 64'(e_drop));
      obs_b.delete();
      exp_b.delete();
      obs_s.delete();
      exp_s.delete();
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_valid"}, 64'(bus.rx_valid), 64'd0);
      chk({tag, "_sof"}, 64'(bus.rx_sof), 64'd0);
      chk({tag, "_eof"}, 64'(bus.rx_eof), 64'd0);
      chk({tag, "_data"}, 64'(bus.rx_data), 64'd0);
      chk({tag, "_stat"}, 64'(bus.rx_stat_valid), 64'd0);
      chk({tag, "_crc_err"}, 64'(bus.rx_crc_err), 64'd0);
      chk({tag, "_len_err"}, 64'(bus.rx_len_err), 64'd0);
      chk({tag, "_frame_cnt"}, 64'(bus.rx_frame_cnt), 64'd0);
      chk({tag, "_crc_cnt"}, 64'(bus.rx_crc_err_cnt), 64'd0);
      chk({tag, "_len_cnt"}, 64'(bus.rx_len_err_cnt), 64'd0);
      chk({tag, "_drop_cnt"}, 64'(bus.rx_drop_cnt), 64'd0);
   endtask

   initial begin
      int         kind;
      logic [7:0] v;
      rst          = 1'b1;
      bus.gmii_den = 1'b0;
      bus.gmii_din = 8'h00;
      e_frame = 0;
      e_crc   = 0;
      e_len   = 0;
      e_drop  = 0;
      repeat (3) @(posedge gmii_clk);
      @(negedge gmii_clk);
      chk_zero("reset");
      @(posedge gmii_clk);
      #1;
      rst = 1'b0;
      repeat (2) @(posedge gmii_clk);

      // good minimum frame
      send_frame(7, 60, 1, 0, 1);
      settle();
      chk("min_beats", 64'(obs_b.size()), (D == 1) ? 64'd64 : 64'd60);
      flush("min");
      chk("min_good", 64'(bus.rx_frame_cnt), 64'd1);

      // corrupted FCS
      send_frame(7, 60, 1, 1, 1);
      flush("badfcs");
      chk("badfcs_cnt", 64'(bus.rx_crc_err_cnt), 64'd1);
      chk("badfcs_good", 64'(bus.rx_frame_cnt), 64'd1);

      // runt and giant
      send_frame(7, 36, 1, 0, 1);
      flush("runt");
      send_frame(7, 1596, 1, 0, 1);
      flush("giant");
      chk("len_cnt", 64'(bus.rx_len_err_cnt), 64'd2);

      // bad preamble
      drive_byte(8'h55);
      drive_byte(8'h55);
      drive_byte(8'hAA);
      for (int k = 0; k < 100; k++) drive_byte(8'($urandom));
      end_burst(1);
      flush("badpre");
      chk("drop_cnt", 64'(bus.rx_drop_cnt), 64'd1);

      // back-to-back with 1-cycle gap, then SFD-only preamble
      send_frame(7, 60, 1, 0, 1);
      send_frame(7, 60, 1, 0, 1);
      flush("b2b");
      chk("b2b_good", 64'(bus.rx_frame_cnt), 64'd3);
      send_frame(0, 60, 1, 0, 1);
      flush("sfdonly");
      chk("sfdonly_good", 64'(bus.rx_frame_cnt), 64'd4);

      // single-byte frame and preamble-only burst
      drive_byte(8'hD5);
      drive_byte(8'($urandom));
      end_burst(1);
      flush("onebyte");
      for (int k = 0; k < 4; k++) drive_byte(8'h55);
      end_burst(2);
      flush("preonly");

      // random mix
      for (int it = 0; it < 40; it++) begin
         kind = $urandom_range(0, 9);
         if (kind == 0) begin
            for (int k = 0; k < $urandom_range(0, 3); k++)
               drive_byte(8'h55);
            do v = 8'($urandom); while (v == 8'h55 || v == 8'hD5);
            drive_byte(v);
            for (int k = 0; k < $urandom_range(0, 20); k++)
               drive_byte(8'($urandom));
            end_burst($urandom_range(1, 3));
         end else if (kind == 1) begin
            for (int k = 0; k < $urandom_range(1, 5); k++)
               drive_byte(8'h55);
            end_burst($urandom_range(1, 3));
         end else if (kind == 2) begin
            send_frame($urandom_range(0, 8), $urandom_range(0, 7),
                       0, 0, $urandom_range(1, 3));
         end else begin
            send_frame($urandom_range(0, 8), $urandom_range(0, 120),
                       1, ($urandom_range(0, 3) == 0),
                       $urandom_range(1, 3));
         end
         if (it % 3 == 2) flush("rand");
      end
      flush("rand");

      // reset mid-frame
      for (int k = 0; k < 7; k++) drive_byte(8'h55);
      drive_byte(8'hD5);
      for (int k = 0; k < 29; k++) drive_byte(8'($urandom));
      @(posedge gmii_clk);
      #1;
      rst          = 1'b1;
      bus.gmii_din = 8'($urandom);
      @(posedge gmii_clk);
      #1;
      bus.gmii_din = 8'($urandom);
      @(negedge gmii_clk);
      chk_zero("midrst");
      cur_b.delete();
      cur_c.delete();
      obs_b.delete();
      obs_s.delete();
      exp_b.delete();
      exp_s.delete();
      e_frame = 0;
      e_crc   = 0;
      e_len   = 0;
      e_drop  = 0;
      drive_byte(8'h00);
      for (int k = 0; k < 30; k++) drive_byte(8'($urandom));
      end_burst(1);
      flush("postrst");
      chk("postrst_drop", 64'(bus.rx_drop_cnt), 64'd1);
      send_frame(7, 60, 1, 0, 1);
      flush("postrst_good");
      chk("postrst_frame", 64'(bus.rx_frame_cnt), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
